// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan panel driver: shifts a row pair from the frame buffer,
// latches it, then lights it for a fixed time before moving to the next.
module hub75_scan_driver #(
   parameter int WIDTH          = 64,
   parameter int HALF_ROWS      = 16,
   parameter int CLK_DIV        = 2,
   parameter int LAT_CYCLES     = 2,
   parameter int DISPLAY_CYCLES = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   output logic [$clog2(WIDTH)-1:0]     fb_x,
   output logic [$clog2(HALF_ROWS):0]   fb_y1,
   output logic [$clog2(HALF_ROWS):0]   fb_y2,
   input  logic [2:0]                   fb_c1,
   input  logic [2:0]                   fb_c2,
   output logic [2:0]                   rgb1,
   output logic [2:0]                   rgb2,
   output logic                         sclk,
   output logic                         lat,
   output logic                         oe_n,
   output logic [$clog2(HALF_ROWS)-1:0] addr,
   output logic                         busy,
   output logic                         frame_done
);

   localparam int XW   = $clog2(WIDTH);
   localparam int RW   = $clog2(HALF_ROWS);
   localparam int C1   = (2 * CLK_DIV > LAT_CYCLES) ? 2 * CLK_DIV : LAT_CYCLES;
   localparam int CMAX = (C1 > DISPLAY_CYCLES) ? C1 : DISPLAY_CYCLES;
   localparam int CW   = $clog2(CMAX);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SHIFT   = 2'd1;
   localparam logic [1:0] LATCH   = 2'd2;
   localparam logic [1:0] DISPLAY = 2'd3;

   logic [1:0]    state;
   logic [XW-1:0] column;
   logic [RW-1:0] row;
   logic [CW-1:0] cnt;

   assign fb_x  = column;
   assign fb_y1 = {1'b0, row};
   assign fb_y2 = {1'b1, row};
   assign busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         column     <= '0;
         row        <= '0;
         cnt        <= '0;
         sclk       <= 1'b0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         rgb1       <= 3'd0;
         rgb2       <= 3'd0;
         addr       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               oe_n <= 1'b1;
               sclk <= 1'b0;
               if (enable) begin
                  state  <= SHIFT;
                  column <= '0;
                  cnt    <= '0;
               end
            end
            SHIFT: begin
               // colour is reloaded every low-phase cycle; the final load
               // coincides with the rising sclk but carries the same value
               if (cnt < CW'(CLK_DIV)) begin
                  rgb1 <= fb_c1;
                  rgb2 <= fb_c2;
               end
               if (cnt == CW'(CLK_DIV - 1))
                  sclk <= 1'b1;
               if (cnt == CW'(2 * CLK_DIV - 1)) begin
                  cnt  <= '0;
                  sclk <= 1'b0;
                  if (column == XW'(WIDTH - 1)) begin
                     column <= '0;
                     addr   <= row;
                     lat    <= 1'b1;
                     state  <= LATCH;
                  end else begin
                     column <= column + XW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            LATCH: begin
               if (cnt == CW'(LAT_CYCLES - 1)) begin
                  cnt   <= '0;
                  lat   <= 1'b0;
                  oe_n  <= 1'b0;
                  state <= DISPLAY;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DISPLAY: begin
               if (cnt == CW'(DISPLAY_CYCLES - 1)) begin
                  cnt        <= '0;
                  oe_n       <= 1'b1;
                  frame_done <= (row == RW'(HALF_ROWS - 1));
                  row        <= (row == RW'(HALF_ROWS - 1)) ? '0 : row + RW'(1);
                  column     <= '0;
                  state      <= enable ? SHIFT : IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: per-cycle comparison against a timing
// model derived from the row schedule, plus a free-running protocol monitor.
module tb_hub75_scan_driver;

   localparam int DISP = 16;
   localparam int SH   = 2 * 2 * 64;
   localparam int RP   = SH + 2 + DISP;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [5:0] fb_x;
   logic [4:0] fb_y1, fb_y2;
   logic [2:0] fb_c1, fb_c2;
   logic [2:0] rgb1, rgb2;
   logic       sclk, lat, oe_n;
   logic [3:0] addr;
   logic       busy, frame_done;

   logic [2:0] img [32][64];
   logic [3:0] exp_addr;
   logic       mon_on = 1'b0;
   logic       prev_oe;
   logic [3:0] prev_addr;
   int         nvec = 0;
   int         nerr = 0;

   hub75_scan_driver #(
      .WIDTH(64), .HALF_ROWS(16), .CLK_DIV(2),
      .LAT_CYCLES(2), .DISPLAY_CYCLES(DISP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .fb_x(fb_x), .fb_y1(fb_y1), .fb_y2(fb_y2),
      .fb_c1(fb_c1), .fb_c2(fb_c2),
      .rgb1(rgb1), .rgb2(rgb2), .sclk(sclk), .lat(lat), .oe_n(oe_n),
      .addr(addr), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always_comb begin
      fb_c1 = img[fb_y1][fb_x];
      fb_c2 = img[fb_y2][fb_x];
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         check("lat_and_oe", {31'd0, lat & ~oe_n}, 32'd0);
         if (!oe_n || !prev_oe)
            check("addr_hold", {28'd0, addr}, {28'd0, prev_addr});
      end
      prev_oe   = oe_n;
      prev_addr = addr;
   end

   // Starts from IDLE at a falling edge and follows nrows rows of the
   // fixed schedule: 256 shift, 2 latch, DISP display cycles per row.
   task automatic run_rows(input int r0, input int nrows,
                           input int drop_t, input int glitch_t);
      int row, p, last;
      enable = 1'b1;
      @(negedge clk);
      for (int t = 0; t < nrows * RP; t++) begin
         row = (r0 + t / RP) % 16;
         p   = t % RP;
         if (p == SH) exp_addr = 4'(row);
         check("busy", busy, 1);
         check("sclk", sclk, (p < SH) && (p % 4 >= 2));
         check("lat", lat, (p >= SH) && (p < SH + 2));
         check("oe_n", oe_n, !(p >= SH + 2));
         check("addr", addr, exp_addr);
         check("fb_y1", fb_y1, row);
         check("fb_y2", fb_y2, row + 16);
         check("fb_x", fb_x, (p < SH) ? p / 4 : 0);
         check("frame_done", frame_done, (t > 0) && (p == 0) && (row == 0));
         if ((p < SH) && (p % 4 >= 2)) begin
            check("rgb1", rgb1, img[row][p / 4]);
            check("rgb2", rgb2, img[row + 16][p / 4]);
         end
         if (t == drop_t) enable = 1'b0;
         if (t == glitch_t) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
      end
      last = (r0 + nrows - 1) % 16;
      check("end_busy", busy, 0);
      check("end_oe_n", oe_n, 1);
      check("end_lat", lat, 0);
      check("end_addr", addr, last);
      check("end_frame_done", frame_done, last == 15);
      @(negedge clk);
      check("idle_frame_done", frame_done, 0);
      check("idle_sclk", sclk, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sclk"}, sclk, 0);
      check({tag, "_lat"}, lat, 0);
      check({tag, "_oe_n"}, oe_n, 1);
      check({tag, "_rgb1"}, rgb1, 0);
      check({tag, "_rgb2"}, rgb2, 0);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int i;
      rst_n  = 1'b0;
      enable = 1'b0;
      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 64; x++)
            img[y][x] = (y < 16) ? 3'(x % 8) : 3'(7 - x % 8);
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n    = 1'b1;
      exp_addr = 4'd0;
      repeat (3) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_oe_n", oe_n, 1);
      end
      mon_on = 1'b1;

      run_rows(0, 1, RP - 1, -1);

      for (int y = 0; y < 32; y++)
         for (int x = 0; x < 64; x++)
            img[y][x] = 3'($urandom);

      // drop enable at row 5 column 20, then resume from row 6
      run_rows(1, 5, 4 * RP + 80, -1);
      repeat (3) @(negedge clk);
      check("paused_addr", addr, 5);
      check("paused_busy", busy, 0);
      run_rows(6, 16, 15 * RP + int'($urandom_range(RP - 1)),
               int'($urandom_range(16 * RP - 2)));

      enable = 1'b1;
      for (i = 0; i < 2 * RP && oe_n !== 1'b0; i++) @(negedge clk);
      check("reach_display", oe_n, 0);
      mon_on = 1'b0;
      rst_n  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      exp_addr = 4'd0;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_busy", busy, 0);
         check("post_rst_oe_n", oe_n, 1);
      end
      mon_on = 1'b1;
      run_rows(0, 1, int'($urandom_range(RP - 1)), 100);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
